// File: rtl/event_tone_gen.sv
// Event-driven square-wave tone generator feeding the audio codec DAC FIFO: a short beep per score tick and a long crash tone on game over.
// Optional TONE_SWEEP_EN: the crash half-period grows by 8 every 1024 pushes, giving a descending pitch.
module event_tone_gen #(
    parameter logic [23:0] AMPLITUDE  = 24'h200000,
    parameter int          BEEP_HALF  = 24,
    parameter int          BEEP_LEN   = 4800,
    parameter int          CRASH_HALF = 96,
    parameter int          CRASH_LEN  = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        score_tick,
    input  logic        game_over,
    input  logic        write_ready,
    output logic        write,
    output logic [23:0] writedata_left,
    output logic [23:0] writedata_right
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEEP  = 2'd1,
        CRASH = 2'd2
    } state_t;

    localparam logic [23:0] POS_SAMPLE  = AMPLITUDE;
    localparam logic [23:0] NEG_SAMPLE  = 24'(~AMPLITUDE + 24'd1);
    localparam logic [23:0] BEEP_LEN_W  = 24'(BEEP_LEN);
    localparam logic [23:0] BEEP_HALF_W = 24'(BEEP_HALF);
    localparam logic [23:0] CRASH_LEN_W = 24'(CRASH_LEN);
    localparam logic [23:0] CRASH_HALF_W = 24'(CRASH_HALF);

    state_t      state_reg;
    logic        write_reg;
    logic        init_hold_reg;
    logic        phase_reg;
    logic        game_over_d_reg;
    logic [23:0] data_reg;
    logic [23:0] len_reg;
    logic [23:0] half_cnt_reg;
    logic [23:0] half_period_reg;
`ifdef TONE_SWEEP_EN
    logic [9:0]  sweep_cnt_reg;
`endif

    logic        go_rise;
    logic        beep_req;
    logic        push_issue;
    logic        half_wrap;
    logic [23:0] sample_next;

    always_comb begin
        go_rise     = game_over && !game_over_d_reg;
        beep_req    = score_tick && !game_over && (state_reg != CRASH);
        // init_hold_reg suppresses a push in the first cycle after reset release
        push_issue  = write_ready && !write_reg && !init_hold_reg;
        half_wrap   = ((half_cnt_reg + 24'd1) >= half_period_reg);
        sample_next = 24'h000000;
        if (state_reg != IDLE) begin
            sample_next = phase_reg ? NEG_SAMPLE : POS_SAMPLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            write_reg       <= 1'b0;
            init_hold_reg   <= 1'b1;
            phase_reg       <= 1'b0;
            game_over_d_reg <= 1'b0;
            data_reg        <= 24'h000000;
            len_reg         <= 24'd0;
            half_cnt_reg    <= 24'd0;
            half_period_reg <= 24'd0;
`ifdef TONE_SWEEP_EN
            sweep_cnt_reg   <= 10'd0;
`endif
        end else begin
            init_hold_reg   <= 1'b0;
            game_over_d_reg <= game_over;
            write_reg       <= push_issue;
            if (push_issue) begin
                data_reg <= sample_next;
            end

            if (go_rise) begin
                state_reg       <= (CRASH_LEN_W == 24'd0) ? IDLE : CRASH;
                len_reg         <= CRASH_LEN_W;
                half_cnt_reg    <= 24'd0;
                phase_reg       <= 1'b0;
                half_period_reg <= CRASH_HALF_W;
`ifdef TONE_SWEEP_EN
                sweep_cnt_reg   <= 10'd0;
`endif
            end else if (beep_req) begin
                state_reg       <= (BEEP_LEN_W == 24'd0) ? IDLE : BEEP;
                len_reg         <= BEEP_LEN_W;
                half_cnt_reg    <= 24'd0;
                phase_reg       <= 1'b0;
                half_period_reg <= BEEP_HALF_W;
            end else if (write_reg && (state_reg != IDLE)) begin
                // tone timing advances only on samples actually pushed
                if (len_reg <= 24'd1) begin
                    state_reg    <= IDLE;
                    len_reg      <= 24'd0;
                    half_cnt_reg <= 24'd0;
                    phase_reg    <= 1'b0;
                end else begin
                    len_reg <= len_reg - 24'd1;
                    if (half_wrap) begin
                        phase_reg    <= ~phase_reg;
                        half_cnt_reg <= 24'd0;
                    end else begin
                        half_cnt_reg <= half_cnt_reg + 24'd1;
                    end
`ifdef TONE_SWEEP_EN
                    if (state_reg == CRASH) begin
                        sweep_cnt_reg <= sweep_cnt_reg + 10'd1;
                        if (sweep_cnt_reg == 10'd1023) begin
                            half_period_reg <= (half_period_reg >= 24'hFFFFF8) ?
                                               24'hFFFFFF : half_period_reg + 24'd8;
                        end
                    end
`endif
                end
            end
        end
    end

    assign write           = write_reg;
    assign writedata_left  = data_reg;
    assign writedata_right = data_reg;

endmodule
